puf_challenge_sequencer: RTL and testbench

Initiator side of the arbiter-PUF interface. It generates challenges with an LFSR and drives the PUF delay-line launch pulse. It samples the single-bit PUF response, majority-votes repeated evaluations of each challenge, and packs the voted bits into a response word. The word is delivered over a valid/ready handshake. It sits between the tile I/O (clk/rst domain) and the arbiter PUF, replacing the raw clk-as-pulse and pin-driven challenge hookup.

---
 rtl/puf_challenge_sequencer.sv | 143 ++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF initiator: LFSR challenges, registered launch pulse, majority-voted
// response bits packed into a word and delivered over valid/ready.
module puf_challenge_sequencer #(
  parameter int                     C_LENGTH  = 8,
  parameter logic [C_LENGTH-1:0]    LFSR_TAPS = 8'hB8,
  parameter int                     RESP_W    = 8,
  parameter int                     VOTES     = 3,
  parameter int                     SETTLE    = 4
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                istart,
  input  logic                iseed_load,
  input  logic [C_LENGTH-1:0] iseed,
  output logic [C_LENGTH-1:0] ochallenge,
  output logic                opulse,
  input  logic                iresponse,
  output logic [RESP_W-1:0]   odata,
  output logic                ovalid,
  input  logic                iready,
  output logic                obusy,
  output logic [7:0]          ounstable
);

  // state | meaning
  // IDLE  | waiting for istart; seed load allowed
  // LOW   | pulse low, challenge muxes settling (SETTLE cycles)
  // HIGH  | pulse high (SETTLE cycles); response sampled on the last one
  // DONE  | word valid, held until iready
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(RESP_W + 1);

  state_t              state_q;
  logic [PW-1:0]       phase_q;
  logic [VW-1:0]       ones_q, votes_q;
  logic [BW-1:0]       bits_q;
  logic [C_LENGTH-1:0] chal_q;
  logic [RESP_W-1:0]   data_q;
  logic [7:0]          unst_q;
  logic                pulse_q, valid_q, busy_q;

  logic [C_LENGTH-1:0] lfsr_d, seed_d;
  logic [VW-1:0]       ones_d, votes_d;
  logic [BW-1:0]       bits_d;
  logic                maj_d, split_d;

  always_comb begin
    lfsr_d  = {chal_q[C_LENGTH-2:0], ^(chal_q & LFSR_TAPS)};
    seed_d  = (iseed == '0) ? C_LENGTH'(1) : iseed;
    ones_d  = ones_q + VW'(iresponse);
    votes_d = votes_q + VW'(1);
    bits_d  = bits_q + BW'(1);
    maj_d   = (ones_d > VW'(VOTES / 2));
    split_d = (ones_d != '0) && (ones_d != VW'(VOTES));
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      ones_q  <= '0;
      votes_q <= '0;
      bits_q  <= '0;
      chal_q  <= C_LENGTH'(1);
      data_q  <= '0;
      unst_q  <= '0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pulse_q <= 1'b0;
          if (iseed_load) chal_q <= seed_d;
          if (istart) begin
            unst_q  <= '0;
            ones_q  <= '0;
            votes_q <= '0;
            bits_q  <= '0;
            phase_q <= PW'(SETTLE - 1);
            busy_q  <= 1'b1;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          if (phase_q == '0) begin
            phase_q <= PW'(SETTLE - 1);
            pulse_q <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            phase_q <= phase_q - PW'(1);
          end
        end
        S_HIGH: begin
          if (phase_q == '0) begin
            phase_q <= PW'(SETTLE - 1);
            pulse_q <= 1'b0;
            if (votes_d < VW'(VOTES)) begin
              ones_q  <= ones_d;
              votes_q <= votes_d;
              state_q <= S_LOW;
            end else begin
              // bit resolved: shift in majority, count disagreement, next challenge
              data_q  <= {data_q[RESP_W-2:0], maj_d};
              if (split_d && (unst_q != 8'hFF)) unst_q <= unst_q + 8'd1;
              chal_q  <= lfsr_d;
              ones_q  <= '0;
              votes_q <= '0;
              bits_q  <= bits_d;
              if (bits_d < BW'(RESP_W)) begin
                state_q <= S_LOW;
              end else begin
                valid_q <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end else begin
            phase_q <= phase_q - PW'(1);
          end
        end
        S_DONE: begin
          if (iready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ochallenge = chal_q;
  assign opulse     = pulse_q;
  assign odata      = data_q;
  assign ovalid     = valid_q;
  assign obusy      = busy_q;
  assign ounstable  = unst_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: table of acquisition runs with a result
// scoreboard, plus hand-written reset, seed and backpressure sequences.
module tb_puf_challenge_sequencer;
  localparam int M_MSB = 0, M_F1 = 1, M_F2 = 2;
  localparam int LAT = 192;

  logic       iclk = 1'b0, irst = 1'b1;
  logic       istart = 1'b0, iseed_load = 1'b0, iready = 1'b1, iresponse = 1'b0;
  logic [7:0] iseed = 8'h00;
  logic [7:0] ochallenge, odata, ounstable;
  logic       opulse, ovalid, obusy;

  puf_challenge_sequencer dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iseed_load(iseed_load), .iseed(iseed),
    .ochallenge(ochallenge), .opulse(opulse), .iresponse(iresponse), .odata(odata),
    .ovalid(ovalid), .iready(iready), .obusy(obusy), .ounstable(ounstable)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic       load;
    logic [7:0] seed;
    int         mode;
    int         bp;
    logic       busy_poke;
    logic [7:0] first, data, unst, after;
  } vec_t;
  typedef struct { logic [7:0] data, unst, after; } exp_t;

  vec_t tbl[5];
  exp_t sbq[$];
  int   n_tests = 0, n_fail = 0;
  int   mode = M_MSB;
  int   run_rises = 0;
  logic pulse_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr(input logic [7:0] c);
    return {c[6:0], ^(c & 8'hB8)};
  endfunction

  function automatic void model_run(input logic [7:0] first, input int m,
                                    output logic [7:0] data, output logic [7:0] unst,
                                    output logic [7:0] after);
    logic [7:0] c;
    int ones;
    c = first; data = 8'h00; unst = 8'h00;
    for (int b = 0; b < 8; b++) begin
      ones = (m == M_MSB) ? (c[7] ? 3 : 0) : ((m == M_F1) ? 1 : 2);
      data = {data[6:0], (ones > 1)};
      if (ones > 0 && ones < 3) unst = unst + 8'd1;
      c = lfsr(c);
    end
    after = c;
  endfunction

  // PUF stand-in: counts launch pulses in the current run and answers per mode
  always @(negedge iclk) begin
    int vidx;
    if (!obusy) run_rises = 0;
    else if (opulse && !pulse_prev) run_rises++;
    pulse_prev = opulse;
    vidx = (run_rises == 0) ? 0 : (run_rises - 1) % 3;
    case (mode)
      M_MSB:   iresponse = ochallenge[7];
      M_F1:    iresponse = (vidx == 0);
      M_F2:    iresponse = (vidx < 2);
      default: iresponse = 1'b0;
    endcase
  end

  // scoreboard consumer: compares on every accepted word
  always @(negedge iclk) begin
    exp_t e;
    if (!irst && ovalid && iready) begin
      if (sbq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_word: got %0h expected none", odata);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", odata, e.data);
        chk("sb_unstable", ounstable, e.unst);
        chk("sb_chal_after", ochallenge, e.after);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    logic [7:0] hd, hc;
    @(posedge iclk); #1;
    mode = v.mode; iseed = v.seed; iseed_load = v.load; istart = 1'b1;
    iready = (v.bp == 0);
    @(posedge iclk); #1;
    istart = 1'b0; iseed_load = 1'b0;
    chk("first_chal", ochallenge, v.first);
    chk("busy_at_start", obusy, 1'b1);
    sbq.push_back('{data: v.data, unst: v.unst, after: v.after});
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge iclk); #1;
      if (v.busy_poke && k == 30) begin iseed = 8'h77; iseed_load = 1'b1; end
      if (v.busy_poke && k == 31) iseed_load = 1'b0;
      if (v.busy_poke && k == 50) istart = 1'b1;
      if (v.busy_poke && k == 51) istart = 1'b0;
      if (ovalid) begin lat = k; break; end
    end
    chk("ovalid_latency", lat, LAT);
    if (lat == 0) return;
    chk("pulse_rises", run_rises, 24);
    if (v.bp > 0) begin
      hd = odata; hc = ochallenge;
      for (int i = 0; i < v.bp; i++) begin
        istart = i[0];
        @(posedge iclk); #1;
        chk("bp_valid", ovalid, 1'b1);
        chk("bp_data", odata, hd);
        chk("bp_chal", ochallenge, hc);
      end
      istart = 1'b0; iready = 1'b1;
    end
    @(posedge iclk); #1;
    chk("valid_drop", ovalid, 1'b0);
    chk("busy_drop", obusy, 1'b0);
    repeat (3) @(posedge iclk);
    #1 chk("idle_stays", obusy, 1'b0);
  endtask

  initial begin
    logic [7:0] d, u, a;
    tbl[0] = '{load: 1, seed: 8'hA5, mode: M_MSB, bp: 0, busy_poke: 0,
               first: 8'hA5, data: 8'hA5, unst: 8'd0, after: 8'h4E};
    model_run(8'h4E, M_F1, d, u, a);
    tbl[1] = '{load: 0, seed: 8'h00, mode: M_F1, bp: 0, busy_poke: 0,
               first: 8'h4E, data: 8'h00, unst: 8'd8, after: a};
    model_run(tbl[1].after, M_F2, d, u, a);
    tbl[2] = '{load: 0, seed: 8'h00, mode: M_F2, bp: 0, busy_poke: 0,
               first: tbl[1].after, data: 8'hFF, unst: 8'd8, after: a};
    model_run(tbl[2].after, M_MSB, d, u, a);
    tbl[3] = '{load: 0, seed: 8'h00, mode: M_MSB, bp: 10, busy_poke: 1,
               first: tbl[2].after, data: d, unst: u, after: a};
    model_run(8'h3C, M_MSB, d, u, a);
    tbl[4] = '{load: 1, seed: 8'h3C, mode: M_MSB, bp: 0, busy_poke: 0,
               first: 8'h3C, data: d, unst: u, after: a};

    #22;
    chk("rst_chal", ochallenge, 8'h01);
    chk("rst_pulse", opulse, 1'b0);
    chk("rst_valid", ovalid, 1'b0);
    chk("rst_busy", obusy, 1'b0);
    chk("rst_data", odata, 8'h00);
    chk("rst_unstable", ounstable, 8'h00);
    @(posedge iclk); #1 irst = 1'b0;

    iseed = 8'hA5; iseed_load = 1'b1;
    @(posedge iclk); #1;
    chk("seed_load", ochallenge, 8'hA5);
    iseed = 8'h00;
    @(posedge iclk); #1;
    iseed_load = 1'b0;
    chk("seed_zero", ochallenge, 8'h01);
    chk("seed_no_start", obusy, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // async reset landing in the middle of a HIGH phase, with state accumulated
    mode = M_F1;
    @(posedge iclk); #1 istart = 1'b1;
    @(posedge iclk); #1 istart = 1'b0;
    repeat (40) @(posedge iclk);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (opulse) begin seen = 1; break; end
        @(posedge iclk);
      end
      chk("mid_high_reached", seen, 1);
    end
    chk("pre_rst_unstable", ounstable, 8'd1);
    @(negedge iclk); #2 irst = 1'b1;
    #1;
    chk("arst_pulse", opulse, 1'b0);
    chk("arst_valid", ovalid, 1'b0);
    chk("arst_busy", obusy, 1'b0);
    chk("arst_chal", ochallenge, 8'h01);
    chk("arst_data", odata, 8'h00);
    chk("arst_unstable", ounstable, 8'h00);
    @(posedge iclk); #1 irst = 1'b0;
    repeat (2) @(posedge iclk);
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
